// File: rtl/nx_msg_packer.sv
// Packs 31-bit Nexus messages into AXI4-stream beats. Each beat carries one
// 32-bit slot per message, and a beat is closed when it is full, on a flush, or after an idle timeout.
module nx_msg_packer #(
  parameter int AXI4_DATA_WIDTH = 128,
  parameter int AXI4_STRB_WIDTH = AXI4_DATA_WIDTH / 8,
  parameter int TIMEOUT         = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [30:0]                ib_nx_data_i,
  input  logic                       ib_nx_valid_i,
  output logic                       ib_nx_ready_o,
  input  logic                       flush_i,
  output logic [AXI4_DATA_WIDTH-1:0] ob_axi4s_tdata_o,
  output logic [AXI4_STRB_WIDTH-1:0] ob_axi4s_tkeep_o,
  output logic                       ob_axi4s_tlast_o,
  output logic                       ob_axi4s_tvalid_o,
  input  logic                       ob_axi4s_tready_i,
  output logic                       idle_o
);

  localparam int SLOTS = AXI4_DATA_WIDTH / 32;
  localparam int CNT_W = $clog2(SLOTS + 1);
  localparam int IDX_W = $clog2(SLOTS);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(SLOTS);
  localparam logic [7:0]       TMO  = 8'(TIMEOUT);

  logic [30:0]                slot_p0 [SLOTS];
  logic [CNT_W-1:0]           cnt_p0;
  logic [CNT_W-1:0]           cnt_nxt;
  logic [7:0]                 idle_cnt_p0;
  logic                       flush_pend_p0;
  logic                       flush_pend_nxt;
  logic [AXI4_DATA_WIDTH-1:0] tdata_p1;
  logic [AXI4_STRB_WIDTH-1:0] tkeep_p1;
  logic                       tlast_p1;
  logic                       vld_p1;
  logic                       close_beat;
  logic                       xfer;
  logic                       accept;
  logic [IDX_W-1:0]           wr_idx;
  logic [AXI4_DATA_WIDTH-1:0] pack_data;
  logic [AXI4_STRB_WIDTH-1:0] pack_keep;

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] lim);
    return (v >= lim) ? lim : v + 8'd1;
  endfunction

  assign close_beat = (cnt_p0 == FULL) ||
                      ((cnt_p0 != '0) && (idle_cnt_p0 == TMO)) ||
                      ((cnt_p0 != '0) && flush_pend_p0);
  assign xfer          = close_beat && (!vld_p1 || ob_axi4s_tready_i);
  assign ib_nx_ready_o = (cnt_p0 < FULL) || xfer;
  assign accept        = ib_nx_valid_i && ib_nx_ready_o;

  // A message arriving while the buffer drains lands in slot 0 of the fresh buffer.
  assign wr_idx  = xfer ? '0 : cnt_p0[IDX_W-1:0];
  assign cnt_nxt = xfer ? CNT_W'(accept) : cnt_p0 + CNT_W'(accept);

  assign flush_pend_nxt = ((flush_pend_p0 && !xfer) || flush_i) && (cnt_nxt != '0);

  always_comb begin
    pack_data = '0;
    pack_keep = '0;
    for (int k = 0; k < SLOTS; k++) begin
      if (CNT_W'(k) < cnt_p0) begin
        pack_data[32*k +: 32] = {1'b1, slot_p0[k]};
        pack_keep[4*k +: 4]   = 4'hF;
      end
    end
  end

  // ---- stage p0: fill buffer ----
  always_ff @(posedge clk_i) begin
    if (accept) begin
      slot_p0[wr_idx] <= ib_nx_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_p0        <= '0;
      idle_cnt_p0   <= '0;
      flush_pend_p0 <= 1'b0;
    end else begin
      cnt_p0        <= cnt_nxt;
      flush_pend_p0 <= flush_pend_nxt;
      if (accept || xfer) begin
        idle_cnt_p0 <= '0;
      end else if (cnt_p0 != '0) begin
        idle_cnt_p0 <= sat_inc(idle_cnt_p0, TMO);
      end
    end
  end

  // ---- stage p1: output register ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1   <= 1'b0;
      tdata_p1 <= '0;
      tkeep_p1 <= '0;
      tlast_p1 <= 1'b0;
    end else if (xfer) begin
      vld_p1   <= 1'b1;
      tdata_p1 <= pack_data;
      tkeep_p1 <= pack_keep;
      // A short beat can only have closed on flush or timeout.
      tlast_p1 <= flush_pend_p0 || (cnt_p0 != FULL);
    end else if (ob_axi4s_tready_i) begin
      vld_p1   <= 1'b0;
    end
  end

  assign ob_axi4s_tdata_o  = tdata_p1;
  assign ob_axi4s_tkeep_o  = tkeep_p1;
  assign ob_axi4s_tlast_o  = tlast_p1;
  assign ob_axi4s_tvalid_o = vld_p1;
  assign idle_o            = (cnt_p0 == '0) && !vld_p1;

endmodule

// File: tb/tb_nx_msg_packer.sv
// Bench for nx_msg_packer: directed beats plus a message scoreboard that checks
// every accepted message comes out exactly once, in order, with stable stalls.
module tb_nx_msg_packer;

  localparam int DW = 128;
  localparam int SW = 16;
  localparam int TO = 16;

  typedef struct {
    logic [DW-1:0] data;
    logic [SW-1:0] keep;
    logic          last;
    int            cyc;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [30:0]   in_data;
  logic          in_valid;
  logic          in_ready;
  logic          flush;
  logic [DW-1:0] tdata;
  logic [SW-1:0] tkeep;
  logic          tlast;
  logic          tvalid;
  logic          tready;
  logic          idle;

  int n_chk = 0;
  int n_err = 0;

  logic [30:0] exp_q [$];
  beat_t       got_q [$];
  int          cyc;
  int          last_acc_cyc;
  logic          prev_stall;
  logic [DW-1:0] prev_data;
  logic [SW-1:0] prev_keep;
  logic          prev_last;

  nx_msg_packer #(
    .AXI4_DATA_WIDTH(DW),
    .AXI4_STRB_WIDTH(SW),
    .TIMEOUT(TO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .ib_nx_data_i(in_data),
    .ib_nx_valid_i(in_valid),
    .ib_nx_ready_o(in_ready),
    .flush_i(flush),
    .ob_axi4s_tdata_o(tdata),
    .ob_axi4s_tkeep_o(tkeep),
    .ob_axi4s_tlast_o(tlast),
    .ob_axi4s_tvalid_o(tvalid),
    .ob_axi4s_tready_i(tready),
    .idle_o(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic score_beat();
    int            n;
    logic [SW-1:0] keep_exp;
    logic [30:0]   e;
    n = 0;
    keep_exp = '0;
    for (int k = 0; k < 4; k++) if (tdata[32*k+31]) n = k + 1;
    for (int k = 0; k < n; k++) keep_exp[4*k +: 4] = 4'hF;
    chk("sb_nonempty", 128'(n > 0), 128'(1'b1));
    chk("sb_keep", 128'(tkeep), 128'(keep_exp));
    for (int k = 0; k < 4; k++) begin
      if (k < n) begin
        chk("sb_used", 128'(tdata[32*k+31]), 128'(1'b1));
        chk("sb_pending", 128'(exp_q.size() > 0), 128'(1'b1));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("sb_msg", 128'(tdata[32*k +: 31]), 128'(e));
        end
      end else begin
        chk("sb_unused", 128'(tdata[32*k +: 32]), 128'(32'h0));
      end
    end
  endtask

  // Monitor: inputs are stable at the falling edge, so handshakes seen here
  // are the ones the next rising edge will commit.
  initial begin
    cyc = 0;
    last_acc_cyc = 0;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        exp_q.delete();
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_tvalid", 128'(tvalid), 128'(1'b1));
          chk("stall_tdata", 128'(tdata), 128'(prev_data));
          chk("stall_tkeep", 128'(tkeep), 128'(prev_keep));
          chk("stall_tlast", 128'(tlast), 128'(prev_last));
        end
        if (tvalid && tready) begin
          score_beat();
          got_q.push_back('{data: tdata, keep: tkeep, last: tlast, cyc: cyc});
        end
        if (in_valid && in_ready) begin
          exp_q.push_back(in_data);
          last_acc_cyc = cyc;
        end
        prev_stall = tvalid && !tready;
        prev_data  = tdata;
        prev_keep  = tkeep;
        prev_last  = tlast;
      end
    end
  end

  task automatic send(input logic [30:0] d, input logic f);
    int   n;
    logic acc;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    flush    = f;
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 200) begin
        chk("send_timeout", 128'(acc), 128'(1'b1));
        break;
      end
    end
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic wait_beats(input int k, input int budget);
    int n;
    n = 0;
    while (got_q.size() < k && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("beat_wait", 128'(got_q.size() >= k), 128'(1'b1));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    beat_t         b;
    logic [DW-1:0] e;

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    flush = 1'b0;
    tready = 1'b1;
    step(2);
    chk("rst_tvalid", 128'(tvalid), 128'(1'b0));
    chk("rst_tdata", 128'(tdata), 128'(0));
    chk("rst_tkeep", 128'(tkeep), 128'(16'h0));
    chk("rst_tlast", 128'(tlast), 128'(1'b0));
    rst = 1'b0;
    step(1);
    chk("rst_ready", 128'(in_ready), 128'(1'b1));
    chk("rst_idle", 128'(idle), 128'(1'b1));

    // Four back-to-back messages make one full beat.
    got_q.delete();
    for (int i = 1; i <= 4; i++) send(31'(i), 1'b0);
    wait_beats(1, 20);
    if (got_q.size() > 0) begin
      b = got_q.pop_front();
      chk("full_data", 128'(b.data), 128'h80000004_80000003_80000002_80000001);
      chk("full_keep", 128'(b.keep), 128'(16'hFFFF));
      chk("full_last", 128'(b.last), 128'(1'b0));
      chk("full_latency", 128'(b.cyc - last_acc_cyc), 128'(2));
    end

    // Two messages, then silence until the timeout closes the beat.
    got_q.delete();
    send(31'h11, 1'b0);
    send(31'h22, 1'b0);
    wait_beats(1, 40);
    if (got_q.size() > 0) begin
      b = got_q.pop_front();
      chk("tmo_data", 128'(b.data), 128'h00000000_00000000_80000022_80000011);
      chk("tmo_keep", 128'(b.keep), 128'(16'h00FF));
      chk("tmo_last", 128'(b.last), 128'(1'b1));
      chk("tmo_latency", 128'(b.cyc - last_acc_cyc), 128'(TO + 2));
    end

    // Downstream stalls for 20 cycles while 12 messages are offered.
    got_q.delete();
    tready = 1'b0;
    fork
      for (int i = 0; i < 12; i++) send(31'(32'h101 + i), 1'b0);
      begin
        step(20);
        chk("stall_ready", 128'(in_ready), 128'(1'b0));
        chk("stall_valid", 128'(tvalid), 128'(1'b1));
        chk("stall_beat1", 128'(tdata), 128'h80000104_80000103_80000102_80000101);
        chk("stall_idle", 128'(idle), 128'(1'b0));
        tready = 1'b1;
      end
    join
    wait_beats(3, 40);
    for (int bi = 0; bi < 3; bi++) begin
      if (got_q.size() > 0) begin
        b = got_q.pop_front();
        for (int j = 0; j < 4; j++) e[32*j +: 32] = {1'b1, 31'(32'h101 + 4*bi + j)};
        chk("stall_order", 128'(b.data), 128'(e));
        chk("stall_bkeep", 128'(b.keep), 128'(16'hFFFF));
        chk("stall_blast", 128'(b.last), 128'(1'b0));
      end
    end

    // Flush together with the third message; then a flush on an empty buffer.
    got_q.delete();
    send(31'h31, 1'b0);
    send(31'h32, 1'b0);
    send(31'h33, 1'b1);
    wait_beats(1, 10);
    if (got_q.size() > 0) begin
      b = got_q.pop_front();
      chk("flush_data", 128'(b.data), 128'h00000000_80000033_80000032_80000031);
      chk("flush_keep", 128'(b.keep), 128'(16'h0FFF));
      chk("flush_last", 128'(b.last), 128'(1'b1));
      chk("flush_latency", 128'(b.cyc - last_acc_cyc), 128'(2));
    end
    step(3);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    step(30);
    chk("empty_flush_nobeat", 128'(got_q.size()), 128'(0));
    chk("empty_flush_idle", 128'(idle), 128'(1'b1));
    send(31'h41, 1'b0);
    step(3);
    chk("flush_pend_cleared", 128'(got_q.size()), 128'(0));
    wait_beats(1, 40);
    if (got_q.size() > 0) begin
      b = got_q.pop_front();
      chk("single_keep", 128'(b.keep), 128'(16'h000F));
      chk("single_last", 128'(b.last), 128'(1'b1));
    end

    // Reset with one beat stalled and three messages buffered.
    got_q.delete();
    tready = 1'b0;
    for (int i = 0; i < 7; i++) send(31'(32'h200 + i), 1'b0);
    step(2);
    chk("prerst_valid", 128'(tvalid), 128'(1'b1));
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("midrst_tvalid", 128'(tvalid), 128'(1'b0));
    chk("midrst_idle", 128'(idle), 128'(1'b1));
    chk("midrst_ready", 128'(in_ready), 128'(1'b1));
    tready = 1'b1;
    send(31'h51, 1'b1);
    wait_beats(1, 10);
    if (got_q.size() > 0) begin
      b = got_q.pop_front();
      chk("postrst_data", 128'(b.data), 128'h00000000_00000000_00000000_80000051);
      chk("postrst_keep", 128'(b.keep), 128'(16'h000F));
    end
    chk("postrst_nodup", 128'(got_q.size()), 128'(0));

    // Random valid/ready/flush traffic checked by the scoreboard.
    for (int i = 0; i < 10000; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 31'($urandom);
      flush    = ($urandom_range(0, 31) == 0);
      tready   = ($urandom_range(0, 3) != 0);
      step(1);
    end
    in_valid = 1'b0;
    tready   = 1'b1;
    flush    = 1'b1;
    step(1);
    flush    = 1'b0;
    step(40);
    chk("rand_drained", 128'(exp_q.size()), 128'(0));
    chk("rand_idle", 128'(idle), 128'(1'b1));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
